// File: rtl/fp16_acc_sched_if.sv
// Stream and adder-side signals of the FP16 packet accumulator.
// slave  : the accumulator itself.
// master : the surrounding logic (term source, fpadder, sum consumer).
interface fp16_acc_sched_if #(
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_last, add_sum, out_ready,
        output in_ready, add_a, add_b, out_valid, out_data, out_count, busy
    );

    modport master (
        output in_valid, in_data, in_last, add_sum, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_data, out_count, busy
    );
endinterface

// File: rtl/fp16_acc_sched.sv
// Sequencer that sums a packet of FP16 terms through one external fpadder.
// The adder registers its core result one edge after the operands appear,
// while its zero/inf/NaN path is combinational, so the operands are held
// through ISSUE and CAPT and the sum is sampled only at the end of CAPT.
module fp16_acc_sched #(
    parameter int CNT_W = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    fp16_acc_sched_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_CAPT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [15:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic [15:0]      r_add_a;
    logic [15:0]      r_add_b;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [15:0]      r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_busy;
    logic [CNT_W-1:0] w_cnt_inc;

    // Term counter saturates instead of wrapping on very long packets.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Sequencer: state, running sum, adder operands and registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_acc       <= 16'h0000;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_add_a     <= 16'h0000;
            r_add_b     <= 16'h0000;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_count <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_acc  <= bus.in_data;
                        r_cnt  <= CNT_W'(1);
                        r_busy <= 1'b1;
                        if (bus.in_last) begin
                            // Single-term packet bypasses the adder entirely.
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= bus.in_data;
                            r_out_count <= CNT_W'(1);
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (bus.in_valid) begin
                        r_add_a    <= r_acc;
                        r_add_b    <= bus.in_data;
                        r_last     <= bus.in_last;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_acc <= bus.add_sum;
                    r_cnt <= w_cnt_inc;
                    if (r_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= bus.add_sum;
                        r_out_count <= w_cnt_inc;
                    end else begin
                        r_state    <= S_FETCH;
                        r_in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_fp16_acc_sched.sv
// Scoreboard bench for fp16_acc_sched with a table-driven fpadder model:
// registered core result, combinational special-case path.
module tb_fp16_acc_sched;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    fp16_acc_sched_if #(.CNT_W(8)) bus ();

    fp16_acc_sched #(.CNT_W(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  count;
        int          lat;
        string       name;
    } exp_t;
    exp_t sb[$];

    // Hand-computed FP16 sums for the operand pairs the vectors produce.
    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case ({a, b})
            {16'h3C00, 16'h4000}: r = 16'h4200;
            {16'h4200, 16'h3800}: r = 16'h4300;
            {16'h7C00, 16'h3C00}: r = 16'h7C00;
            {16'h0000, 16'hC000}: r = 16'hC000;
            {16'h3C00, 16'h3C00}: r = 16'h4000;
            {16'h4000, 16'h4000}: r = 16'h4400;
            {16'h0000, 16'h0000}: r = 16'h0000;
            default:              r = 16'h7E55;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [15:0] v);
        return (v[14:10] == 5'h1F) || (v[14:0] == 15'h0000);
    endfunction

    logic [15:0] r_core;
    always @(posedge CLK) r_core <= fadd(bus.add_a, bus.add_b);
    assign bus.add_sum = (is_special(bus.add_a) || is_special(bus.add_b))
                         ? fadd(bus.add_a, bus.add_b) : r_core;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Present one term from a negedge and return at the negedge after it is taken.
    task automatic put(input logic [15:0] d, input bit last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
        else @(negedge CLK);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send(input logic [15:0] t[4], input int n, input logic [15:0] sum,
                        input int lat, input string nm);
        exp_t e;
        e.data  = sum;
        e.count = 8'(n);
        e.lat   = lat;
        e.name  = nm;
        sb.push_back(e);
        for (int i = 0; i < n; i++) put(t[i], i == n - 1);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) begin
            chk({nm, "_done_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    // Monitor: samples late in the low phase, well away from the rising edge.
    int          start_cyc = 0;
    int          phase = 0;
    logic [15:0] rec_b, hold_a, hold_b, hold_d;
    logic [7:0]  hold_c;
    bit          prev_ov = 1'b0;
    bit          post_hs = 1'b0;
    always begin
        @(negedge CLK);
        #3;
        if (RESET) begin
            prev_ov = 1'b0;
            phase   = 0;
            post_hs = 1'b0;
        end else begin
            if (post_hs) begin
                chk("idle_busy", 32'(bus.busy), 32'd0);
                chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
                chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
                post_hs = 1'b0;
            end
            if (bus.in_valid && bus.in_ready && !bus.busy) start_cyc = cyc;
            case (phase)
                1: begin
                    chk("issue_add_b", 32'(bus.add_b), 32'(rec_b));
                    chk("issue_in_ready", 32'(bus.in_ready), 32'd0);
                    hold_a = bus.add_a;
                    hold_b = bus.add_b;
                    phase  = 2;
                end
                2: begin
                    chk("capt_add_a_held", 32'(bus.add_a), 32'(hold_a));
                    chk("capt_add_b_held", 32'(bus.add_b), 32'(hold_b));
                    chk("capt_in_ready", 32'(bus.in_ready), 32'd0);
                    phase = 0;
                end
                default: ;
            endcase
            if (bus.in_valid && bus.in_ready && bus.busy) begin
                rec_b = bus.in_data;
                phase = 1;
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    if (!prev_ov) begin
                        if (sb[0].lat >= 0)
                            chk({sb[0].name, "_latency"}, 32'(cyc - start_cyc), 32'(sb[0].lat));
                        hold_d = bus.out_data;
                        hold_c = bus.out_count;
                    end else begin
                        chk({sb[0].name, "_data_stable"}, 32'(bus.out_data), 32'(hold_d));
                        chk({sb[0].name, "_count_stable"}, 32'(bus.out_count), 32'(hold_c));
                    end
                    chk({sb[0].name, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
                    if (bus.out_ready) begin
                        chk({sb[0].name, "_data"}, 32'(bus.out_data), 32'(sb[0].data));
                        chk({sb[0].name, "_count"}, 32'(bus.out_count), 32'(sb[0].count));
                        $display("pkt %s: out_data=%h out_count=%0d (expected %h/%0d)",
                                 sb[0].name, bus.out_data, bus.out_count, sb[0].data, sb[0].count);
                        void'(sb.pop_front());
                        post_hs = 1'b1;
                    end
                end
                prev_ov = !bus.out_ready;
            end else begin
                prev_ov = 1'b0;
            end
        end
    end

    initial begin
        logic [15:0] t[4];
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk("rst_add_a", 32'(bus.add_a), 32'd0);
        chk("rst_add_b", 32'(bus.add_b), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single term: bit-exact bypass, adder operands untouched.
        t[0] = 16'h5A3C;
        send(t, 1, 16'h5A3C, 1, "single");
        wait_idle("single");
        chk("single_add_a", 32'(bus.add_a), 32'd0);
        chk("single_add_b", 32'(bus.add_b), 32'd0);

        t[0] = 16'h3C00; t[1] = 16'h4000;
        send(t, 2, 16'h4200, 4, "two_term");
        wait_idle("two_term");

        t[0] = 16'h3C00; t[1] = 16'h4000; t[2] = 16'h3800;
        send(t, 3, 16'h4300, 7, "three_term");
        wait_idle("three_term");

        t[0] = 16'h7C00; t[1] = 16'h3C00;
        send(t, 2, 16'h7C00, 4, "inf_plus_one");
        wait_idle("inf_plus_one");

        t[0] = 16'h0000; t[1] = 16'hC000;
        send(t, 2, 16'hC000, 4, "zero_plus_m2");
        wait_idle("zero_plus_m2");

        // Back-pressure: hold the result for five cycles.
        bus.out_ready = 1'b0;
        t[0] = 16'h3C00; t[1] = 16'h4000;
        send(t, 2, 16'h4200, 4, "backpressure");
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("bp_out_valid_timeout", 32'd0, 32'd1);
        repeat (5) @(negedge CLK);
        bus.out_ready = 1'b1;
        wait_idle("backpressure");

        // Reset during CAPT of a three-term packet drops the partial sum.
        put(16'h3C00, 1'b0);
        put(16'h3C00, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_add_a", 32'(bus.add_a), 32'd0);

        t[0] = 16'h4000; t[1] = 16'h4000;
        send(t, 2, 16'h4400, 4, "after_reset");
        wait_idle("after_reset");

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
